// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM encoding,
// port identifiers and the access descriptor latched at grant time.
package data_mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic        id;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
  } acc_t;

  // A word address is legal only if nothing is set above the implemented bits.
  function automatic logic addr_in_range(input logic [31:0] adr, input int abits);
    return (adr >> abits) == 32'd0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick: req[0] is port A, req[1] is port B.
// On contention the port that was not granted last wins.
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = PORT_A;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req == 2'b10) begin
      winner = PORT_B;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU (A) and debug/DMA (B) ports onto a single-ported data memory
// with a fixed IDLE -> ACCESS -> DONE sequence, one access every three cycles.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_BITS = 5
) (
  input  logic        MEM_clk,
  input  logic        MEM_rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_adr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_adr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic        mem_wren,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic        last_reg;
  acc_t        acc_reg;
  acc_t        win_acc;
  logic        winner;
  logic        any_req;
  logic        in_range;
  logic        accept;
  logic [1:0]  gnt_vec;
  logic [1:0]  done_vec;
  logic [1:0]  err_vec;
  logic [31:0] rdata_vec [2];

  rr_arb2 u_rr_arb2 (
    .req    ({b_req, a_req}),
    .last   (last_reg),
    .winner (winner)
  );

  assign any_req  = a_req | b_req;
  assign accept   = (state_reg == IDLE) && any_req;
  assign in_range = addr_in_range(acc_reg.adr, ADDR_BITS);

  always_comb begin
    win_acc.id    = winner;
    win_acc.we    = (winner == PORT_B) ? b_we    : a_we;
    win_acc.adr   = (winner == PORT_B) ? b_adr   : a_adr;
    win_acc.wdata = (winner == PORT_B) ? b_wdata : a_wdata;
  end

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = any_req ? ACCESS : IDLE;
      ACCESS:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge MEM_clk or negedge MEM_rst_n) begin
    if (!MEM_rst_n) begin
      state_reg <= IDLE;
      last_reg  <= PORT_B;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_reg <= winner;
        acc_reg  <= win_acc;
      end
    end
  end

  // Per-port response decode; only the served port ever sees nonzero values.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic PID = (gi == 0) ? PORT_A : PORT_B;
    logic sel;
    assign sel            = (acc_reg.id == PID);
    assign gnt_vec[gi]    = (state_reg == ACCESS) && sel;
    assign done_vec[gi]   = (state_reg == DONE) && sel;
    assign err_vec[gi]    = (state_reg == DONE) && sel && !in_range;
    assign rdata_vec[gi]  = ((state_reg == DONE) && sel && !acc_reg.we && in_range)
                            ? mem_dout : 32'd0;
  end

  assign a_gnt   = gnt_vec[0];
  assign a_done  = done_vec[0];
  assign a_err   = err_vec[0];
  assign a_rdata = rdata_vec[0];
  assign b_gnt   = gnt_vec[1];
  assign b_done  = done_vec[1];
  assign b_err   = err_vec[1];
  assign b_rdata = rdata_vec[1];

  assign mem_wren = (state_reg == ACCESS) && acc_reg.we && in_range;
  assign mem_adr  = (state_reg == IDLE) ? 32'd0 : acc_reg.adr;
  assign mem_din  = (state_reg == IDLE) ? 32'd0 : acc_reg.wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and random checks of data_mem_arbiter against a transaction-level
// model of the arbiter and a shadow copy of the 32-word memory.
module tb_data_mem_arbiter;

  logic        MEM_clk = 1'b0;
  logic        MEM_rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_adr, a_wdata, b_adr, b_wdata;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_wren;
  logic [31:0] mem_adr, mem_din, mem_dout;

  int checks   = 0;
  int failures = 0;

  data_mem_arbiter #(.ADDR_BITS(5)) dut (
    .MEM_clk(MEM_clk), .MEM_rst_n(MEM_rst_n),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_wren(mem_wren), .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 MEM_clk = ~MEM_clk;

  // Memory with registered read; loads a seeded pattern while mem_init is high.
  logic [31:0] ram [32];
  logic        mem_init;
  logic [31:0] seed;
  always @(posedge MEM_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) ram[i] <= seed ^ (32'h0101_0101 * i);
      mem_dout <= 32'd0;
    end else begin
      if (mem_wren) ram[mem_adr[4:0]] <= mem_din;
      mem_dout <= ram[mem_adr[4:0]];
    end
  end

  // Reference model: phase 0 idle, 1 granted, 2 completing.
  int          phase = 0;
  bit          srv = 0, last = 1, s_we = 0;
  logic [31:0] s_adr = 0, s_wd = 0;
  logic [31:0] ref_mem [32];
  bit          pend [2];
  bit          p_we [2];
  logic [31:0] p_adr [2];
  logic [31:0] p_wd [2];
  bit          grants [$];

  function automatic bit inr(input logic [31:0] a);
    return a[31:5] == 27'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    a_req = pend[0]; a_we = p_we[0]; a_adr = p_adr[0]; a_wdata = p_wd[0];
    b_req = pend[1]; b_we = p_we[1]; b_adr = p_adr[1]; b_wdata = p_wd[1];
  endtask

  task automatic verify();
    bit          rng = inr(s_adr);
    logic [6:0]  e_ctl;
    logic [31:0] e_rd;
    e_ctl = {phase == 1 && !srv, phase == 2 && !srv, phase == 2 && !srv && !rng,
             phase == 1 &&  srv, phase == 2 &&  srv, phase == 2 &&  srv && !rng,
             phase == 1 && s_we && rng};
    e_rd  = (phase == 2 && !s_we && rng) ? ref_mem[s_adr[4:0]] : 32'd0;
    check("ctl", {25'd0, a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_wren}, {25'd0, e_ctl});
    check("mem_adr", mem_adr, (phase == 0) ? 32'd0 : s_adr);
    check("mem_din", mem_din, (phase == 0) ? 32'd0 : s_wd);
    check("a_rdata", a_rdata, srv ? 32'd0 : e_rd);
    check("b_rdata", b_rdata, srv ? e_rd : 32'd0);
  endtask

  task automatic tick();
    drive();
    if (!MEM_rst_n) begin
      phase = 0; last = 1;
    end else if (phase == 0) begin
      if (pend[0] || pend[1]) begin
        srv   = (pend[0] && pend[1]) ? !last : !pend[0];
        last  = srv;
        s_we  = p_we[srv]; s_adr = p_adr[srv]; s_wd = p_wd[srv];
        phase = 1;
      end
    end else if (phase == 1) begin
      if (s_we && inr(s_adr)) ref_mem[s_adr[4:0]] = s_wd;
      phase = 2;
    end else begin
      phase = 0;
    end
    @(posedge MEM_clk); #1;
    if (a_gnt) grants.push_back(1'b0);
    if (b_gnt) grants.push_back(1'b1);
    if (phase == 1) pend[srv] = 0;
    verify();
    drive();
  endtask

  task automatic issue(input int p, input bit we, input logic [31:0] adr, input logic [31:0] wd);
    pend[p] = 1; p_we[p] = we; p_adr[p] = adr; p_wd[p] = wd;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) if (phase != 0 || pend[0] || pend[1]) tick();
  endtask

  logic [31:0] w0;

  initial begin
    seed = $urandom;
    for (int i = 0; i < 32; i++) ref_mem[i] = seed ^ (32'h0101_0101 * i);
    for (int p = 0; p < 2; p++) begin pend[p] = 0; p_we[p] = 0; p_adr[p] = 0; p_wd[p] = 0; end
    mem_init = 1'b1;
    MEM_rst_n = 1'b0;
    drive();
    #2;
    verify();
    repeat (2) @(posedge MEM_clk);
    #1;
    mem_init  = 1'b0;
    MEM_rst_n = 1'b1;
    verify();

    // Both ports held high from reset: A, B, A, B.
    grants.delete();
    issue(0, 0, 32'd5, 32'd0);
    issue(1, 0, 32'd9, 32'd0);
    for (int i = 0; i < 13; i++) begin
      tick();
      if (grants.size() < 4) begin pend[0] = 1; pend[1] = 1; end
      else begin pend[0] = 0; pend[1] = 0; end
    end
    check("rr_count", grants.size(), 32'd4);
    if (grants.size() >= 4)
      check("rr_order", {28'd0, grants[0], grants[1], grants[2], grants[3]}, 32'b0101);
    drain();

    // A write then A read of word 3.
    issue(0, 1, 32'd3, 32'hDEADBEEF);
    tick();
    check("wr_gnt", {31'd0, a_gnt}, 32'd1);
    check("wr_wren", {31'd0, mem_wren}, 32'd1);
    tick();
    check("wr_wren_off", {31'd0, mem_wren}, 32'd0);
    tick();
    issue(0, 0, 32'd3, 32'd0);
    tick();
    check("rd_gnt", {31'd0, a_gnt}, 32'd1);
    tick();
    check("rd_done", {31'd0, a_done}, 32'd1);
    check("rd_data", a_rdata, 32'hDEADBEEF);
    drain();

    // Out-of-range B write must not touch memory.
    w0 = ref_mem[0];
    issue(1, 1, 32'h40, 32'h1234_5678);
    tick();
    check("oor_wren", {31'd0, mem_wren}, 32'd0);
    tick();
    check("oor_done_err", {30'd0, b_done, b_err}, 32'd3);
    tick();
    issue(0, 0, 32'd0, 32'd0);
    tick(); tick();
    check("oor_word0", a_rdata, w0);
    drain();

    // B raised while A is in flight waits for IDLE.
    issue(0, 0, 32'd12, 32'd0);
    tick();
    issue(1, 1, 32'd13, 32'hCAFE_F00D);
    tick();
    check("late_b_nognt", {31'd0, b_gnt}, 32'd0);
    check("a_done_kept", {31'd0, a_done}, 32'd1);
    tick(); tick();
    check("late_b_gnt", {31'd0, b_gnt}, 32'd1);
    drain();

    // Asynchronous reset in the middle of an A access.
    issue(0, 1, 32'd7, 32'h7777_0000);
    tick();
    #3;
    MEM_rst_n = 1'b0;
    #1;
    phase = 0; last = 1;
    check("rst_async_wren", {31'd0, mem_wren}, 32'd0);
    verify();
    issue(0, 1, 32'd7, 32'h7777_0000);
    tick(); tick();
    MEM_rst_n = 1'b1;
    tick();
    check("rst_regrant", {31'd0, a_gnt}, 32'd1);
    drain();

    // Random traffic from both ports.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          logic [31:0] adr;
          adr = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h20) : 32'($urandom_range(0, 31));
          issue(p, 1'($urandom_range(0, 1)), adr, $urandom);
        end
      end
      tick();
    end
    pend[0] = 0; pend[1] = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: ADDR_BITS, 5, word-address bits implemented by the data memory (32 words).
REQ-002 MEM_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 MEM_rst_n  in  1  asynchronous, active-low reset.
REQ-004 a_req, a_we  in  1 each  port A (CPU) request and write-enable qualifier.
REQ-005 a_adr, a_wdata  in  32 each  port A word address and write data.
REQ-006 a_gnt, a_done, a_err  out  1 each  port A accept pulse, completion pulse and range-error flag.
REQ-007 a_rdata  out  32  port A read data, valid while a_done=1 for a read.
REQ-008 b_req, b_we, b_adr, b_wdata, b_gnt, b_done, b_err, b_rdata: port B (debug/DMA), same widths and meaning as port A.
REQ-009 mem_wren  out  1  memory write enable.
REQ-010 mem_adr, mem_din  out  32 each  memory word address and write data.
REQ-011 mem_dout  in  32  memory read data, registered inside the memory on MEM_clk.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-013 In IDLE with any req=1, the arbiter SHALL latch the winner's id, we, adr and wdata at the edge and enter ACCESS.
REQ-014 Arbitration SHALL be round-robin: with both requests high, the port not granted last wins; after reset, A is treated as the higher priority.
REQ-015 Requests SHALL be sampled only in IDLE; req in ACCESS/DONE is ignored, and a requester keeps req high until gnt or it is never served.
REQ-016 x_gnt SHALL be high for exactly the ACCESS cycle of the granted port; the requester may drop req from the next cycle.
REQ-017 In ACCESS and DONE, mem_adr SHALL equal the latched address and mem_din the latched wdata; in IDLE both SHALL be 0.
REQ-018 mem_wren SHALL be 1 only in ACCESS, only for a write, and only if the address is in range.
REQ-019 An address is out of range when bits [31:ADDR_BITS] are nonzero; such an access SHALL NOT write memory and SHALL assert x_err with x_done.
REQ-020 The next ACCESS -> DONE transition SHALL be unconditional; DONE -> IDLE SHALL also be unconditional (throughput: one access per 3 cycles).
REQ-021 In DONE, x_done SHALL be high for one cycle for the served port only; for an in-range read, x_rdata SHALL equal mem_dout, otherwise 0.
REQ-022 The latency from an edge sampling req in IDLE SHALL be: gnt in the following cycle and done in the cycle after that.
REQ-023 The non-served port's gnt, done, err and rdata SHALL be 0 in every cycle.
REQ-024 The round-robin pointer SHALL update at the IDLE->ACCESS edge to the granted id.

Reset
REQ-025 Asserting MEM_rst_n=0 SHALL immediately force IDLE, the pointer to "last=B" (A favoured), and all outputs to 0, including mem_wren.
REQ-026 Reset mid-ACCESS SHALL abort the access with no done pulse; whether memory was written at the coincident edge is undefined, and the requester re-issues.
REQ-027 The first possible acceptance after reset release SHALL be the first rising edge at which MEM_rst_n=1.

Structure
REQ-028 A shared package data_mem_arb_pkg SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the port ids PORT_A=1'b0 and PORT_B=1'b1.
REQ-029 The two-input round-robin grant logic SHALL be the sub-module rr_arb2 (inputs req[1:0], last; output winner id), used by the FSM.

Verification
REQ-030 A write with adr=3 and wdata=0xDEADBEEF, then an A read of adr=3 -> a_gnt at cycle+1; mem_wren=1 only in that cycle; a_done at cycle+2 with a_rdata=0xDEADBEEF.
REQ-031 a_req and b_req held high for 4 accesses from reset -> grant order A, B, A, B; never both gnt or both done.
REQ-032 A B write with adr=0x40 -> mem_wren stays 0, b_done=1 and b_err=1 together, and a subsequent read of word 0 is unchanged.
REQ-033 b_req raised during A's ACCESS -> B is ignored until IDLE, then granted; A's done is unaffected.
REQ-034 MEM_rst_n pulled low during ACCESS -> all outputs 0 asynchronously, no a_done, and after release a held a_req is granted normally.
